// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-addressed SRAM responder with 2-cycle ERROR replies.
// Optional macro AHB_SRAM_WAIT_STATE_EN adds one wait state to every legal read.
module ahb_sram_slave #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);

`ifdef AHB_SRAM_WAIT_STATE_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2, S_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx_p1;
  logic              write_p1;

  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              bad;
  logic              accept;
  logic              commit;
  logic              fwd;
  logic              unused;

  // Address phase: decode the beat presented on the bus this cycle
  assign offset = HADDR - BASE_ADDR;
  assign idx    = offset[IDX_W-1:0];
  assign bad    = (HSIZE != 3'b010) || (offset >= 32'(DEPTH));
  assign accept = HSEL && HREADY && HTRANS[1];
  assign commit = (state == S_DATA) && write_p1;
  assign fwd    = commit && (idx_p1 == idx);
  assign unused = ^{HBURST, HTRANS[0]};

  // Data phase: state, registered bus outputs and array update
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      idx_p1    <= '0;
      write_p1  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (commit) mem[idx_p1] <= HWDATA;
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      case (state)
        S_ERR1: begin
          state <= S_ERR2;
          HRESP <= 1'b1;
        end
`ifdef AHB_SRAM_WAIT_STATE_EN
        S_WAIT: begin
          state  <= S_DATA;
          HRDATA <= mem[idx_p1];
        end
`endif
        default: begin
          if (accept) begin
            idx_p1   <= idx;
            write_p1 <= HWRITE;
            if (bad) begin
              state     <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (HWRITE) begin
              state <= S_DATA;
`ifdef AHB_SRAM_WAIT_STATE_EN
            end else begin
              state     <= S_WAIT;
              HREADYOUT <= 1'b0;
            end
`else
            end else begin
              // A write to the same word is committing on this very edge
              state  <= S_DATA;
              HRDATA <= fwd ? HWDATA : mem[idx];
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: stimulus queues expected data-phase
// responses, an independent bus monitor pops and compares them.
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 64;
`ifdef AHB_SRAM_WAIT_STATE_EN
  localparam int RD_WAIT = 1;
`else
  localparam int RD_WAIT = 0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] WORD = 3'b010;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = T_IDLE;
  logic [2:0]  HSIZE = WORD;
  logic [2:0]  HBURST = 3'b001;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADYOUT), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        resp;
    logic [31:0] data;
    int          nwait;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [31:0] pend_wdata = '0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One address phase; held until the slave's ready is seen high at the edge
  task automatic beat(input logic [1:0] trans, input logic [31:0] off, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic eresp, input logic [31:0] edata, input int nwait,
                      input string name);
    logic r;
    int   n;
    exp_t e;
    if (trans[1]) begin
      e.resp = eresp; e.data = edata; e.nwait = nwait; e.name = name;
      q.push_back(e);
    end
    HSEL = 1'b1; HTRANS = trans; HADDR = BASE + off; HWRITE = wr; HSIZE = size;
    HWDATA = pend_wdata;
    pend_wdata = wdata;
    n = 0;
    do begin
      @(negedge HCLK);
      r = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end while (!r && n < 20);
    check({name, "_ready_timeout"}, 40'(r), 40'(1));
  endtask

  task automatic idle();
    beat(T_IDLE, 32'h0, 1'b0, WORD, 32'h0, 1'b0, 32'h0, 0, "idle");
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input string name);
    beat(T_NSEQ, off, 1'b1, WORD, d, 1'b0, 32'h0, 0, name);
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] d, input string name);
    beat(T_NSEQ, off, 1'b0, WORD, 32'h0, 1'b0, d, RD_WAIT, name);
  endtask

  // Bus monitor: tracks accepted beats and scores every cycle's response
  initial begin
    logic in_dphase;
    logic rdy_s;
    int   waits;
    exp_t e;
    in_dphase = 1'b0;
    waits = 0;
    forever begin
      @(negedge HCLK);
      rdy_s = HREADYOUT;
      if (mon_en) begin
        if (!HRESETn) begin
          in_dphase = 1'b0;
          check("reset_outputs", 40'({HREADYOUT, HRESP, HRDATA}), 40'({1'b1, 1'b0, 32'h0}));
        end else if (in_dphase) begin
          if (q.size() == 0) begin
            check("unexpected_dphase", 40'(1), 40'(0));
            in_dphase = 1'b0;
          end else if (!HREADYOUT) begin
            waits++;
            check({q[0].name, "_waitcyc"}, 40'({HRESP, HRDATA}), 40'({q[0].resp, 32'h0}));
          end else begin
            e = q.pop_front();
            check(e.name, 40'({HRESP, HRDATA}), 40'({e.resp, e.data}));
            check({e.name, "_waits"}, 40'(waits), 40'(e.nwait));
            in_dphase = 1'b0;
          end
        end else begin
          check("idle_cycle", 40'({HREADYOUT, HRESP, HRDATA}), 40'({1'b1, 1'b0, 32'h0}));
        end
      end
      @(posedge HCLK);
      if (mon_en && HRESETn && HSEL && rdy_s && HTRANS[1]) begin
        in_dphase = 1'b1;
        waits = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with a NONSEQ read on the bus
    HRESETn = 1'b0; HSEL = 1'b1; HTRANS = T_NSEQ; HADDR = BASE + 5; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HTRANS = T_IDLE;
    rd(5, 32'h0, "rd_after_reset");
    idle();

    // Single write, then read
    wr(3, 32'hDEAD_BEEF, "wr3");
    idle();
    rd(3, 32'hDEAD_BEEF, "rd3");
    idle();

    // Deselected NONSEQ must not be served
    HSEL = 1'b0; HTRANS = T_NSEQ; HADDR = BASE + 3; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = T_IDLE;
    idle();

    // Preload 10..7, then decrementing burst with a BUSY after 9
    wr(10, 32'h10, "pre10");
    beat(T_SEQ, 9, 1'b1, WORD, 32'h09, 1'b0, 32'h0, 0, "pre9");
    beat(T_SEQ, 8, 1'b1, WORD, 32'h08, 1'b0, 32'h0, 0, "pre8");
    beat(T_SEQ, 7, 1'b1, WORD, 32'h07, 1'b0, 32'h0, 0, "pre7");
    idle();
    rd(10, 32'h10, "burst10");
    beat(T_SEQ, 9, 1'b0, WORD, 32'h0, 1'b0, 32'h09, RD_WAIT, "burst9");
    beat(T_BUSY, 8, 1'b0, WORD, 32'h0, 1'b0, 32'h0, 0, "busy");
    beat(T_SEQ, 8, 1'b0, WORD, 32'h0, 1'b0, 32'h08, RD_WAIT, "burst8");
    beat(T_SEQ, 7, 1'b0, WORD, 32'h0, 1'b0, 32'h07, RD_WAIT, "burst7");
    idle();

    // Errors: above window, below window, bad size write
    wr(2, 32'h22, "wr2");
    idle();
    beat(T_NSEQ, DEPTH, 1'b0, WORD, 32'h0, 1'b1, 32'h0, 1, "err_above");
    idle();
    beat(T_NSEQ, 32'hFFFF_FFFF, 1'b0, WORD, 32'h0, 1'b1, 32'h0, 1, "err_below");
    idle();
    beat(T_NSEQ, 2, 1'b1, 3'b000, 32'h0000_0BAD, 1'b1, 32'h0, 1, "err_size");
    idle();
    rd(2, 32'h22, "rd2_unchanged");
    idle();

    // Pipelined write then read of the same word
    wr(0, 32'h1234_5678, "wr0");
    rd(0, 32'h1234_5678, "rd0_pipelined");
    idle();

    // Read of a stored pattern, write directly after
    wr(1, 32'hA5A5_A5A5, "wr1");
    idle();
    rd(1, 32'hA5A5_A5A5, "rd1");
    wr(4, 32'h0000_0044, "wr4_after_rd");
    idle();
    rd(4, 32'h0000_0044, "rd4");
    idle();

    // Reset in the data phase of a write clears the array
    wr(5, 32'h55, "wr5");
    idle();
    HTRANS = T_NSEQ; HADDR = BASE + 6; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HRESETn = 1'b0; HTRANS = T_IDLE; HWDATA = 32'h66;
    @(posedge HCLK); #1;
    HRESETn = 1'b1; pend_wdata = '0;
    rd(5, 32'h0, "rd5_cleared");
    rd(6, 32'h0, "rd6_dropped");
    rd(3, 32'h0, "rd3_cleared");
    idle();
    idle();

    check("queue_drained", 40'(q.size()), 40'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder holding a word-addressed SRAM window. It is the target end of the read DMA masters' transfers: it serves NONSEQ/SEQ read and write beats, including decrementing-address INCR bursts and strings of SINGLE transfers. It sits on the system bus behind the decoder's HSEL and provides both buffer storage and a protocol-checking endpoint for DMA bring-up.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; legal values are powers of two, 2..1024.
- BASE_ADDR, 32'h0000_0000: first word address of the window. HADDR counts words, not bytes, matching the DMA masters.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  reset; one clock, synchronous, active-low.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  word address.
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  only WORD (3'b010) is legal.
- HBURST  in  3  accepted and ignored; each beat is handled on its own.
- HWDATA  in  32  write data, valid in the write data phase.
- HREADY  in  1  bus-wide ready (mux output).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Accept rule.** A beat is accepted on a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS[1]=1.
  - On acceptance, register the address-phase signals: offset = HADDR − BASE_ADDR (32-bit modular), HWRITE, and an error flag.
  - IDLE/BUSY beats, and cycles with HSEL=0, are not accepted. They get an OKAY, zero-wait response.
- **Error flag.** Set when HSIZE ≠ 3'b010 or offset ≥ DEPTH. Above BASE_ADDR+DEPTH−1 and below BASE_ADDR (wrapped offset) are both errors.
- **State machine** (IDLE, DATA, ERR1, ERR2):
  - IDLE: HREADYOUT=1, HRESP=OKAY, HRDATA=0. An accepted legal beat → DATA. An accepted illegal beat → ERR1.
  - DATA, read: HRDATA = mem[offset], HREADYOUT=1.
  - DATA, write: mem[offset] ← HWDATA on the closing edge.
  - Leaving DATA: a new accepted beat in the same cycle (pipelined) → DATA or ERR1, chosen by that beat's flag. Otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=0. No accept in this cycle (HREADY=0). → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. The beat presented in this cycle may be accepted, with the same transitions as from DATA.
- **Memory.** The array is not written by an errored beat. All words clear to 0 on reset.
- **Back-to-back write then read, same offset.** The read data phase returns the new value. The write commits on the edge that starts the read data phase.
- **Decrementing bursts.** Need no special handling. Each SEQ beat carries its own HADDR.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, all memory words 0.
- Reset asserted mid-transfer aborts the beat. The next edge restores the reset values and drops any pending write.
- Read latency: data appears in the cycle after the address phase (zero wait states), unless the configuration macro below is defined.
- Write latency: zero wait. Data is captured at the end of the data phase.
- Error response is always exactly 2 cycles: ERR1 then ERR2.
- Whenever HREADYOUT=1, HRDATA is 0 outside read data phases.

## Configuration
- Macro: AHB_SRAM_WAIT_STATE_EN.
- Defined:
  - Every legal read data phase gets exactly one wait state (extra WAIT state): first cycle HREADYOUT=0, HRDATA=0, HRESP=0; second cycle HREADYOUT=1 with the data.
  - No accept is possible during the wait cycle.
  - Writes and errors are unchanged.
- Undefined: WAIT state and logic are absent. Reads are zero-wait.

## Test plan
- **Reset.** Hold HRESETn=0 for 2 cycles with HSEL=1, HTRANS=NONSEQ → HREADYOUT=1, HRESP=0, HRDATA=0. A subsequent read of offset 5 returns 0.
- **Single write/read.** Write 32'hDEAD_BEEF to BASE_ADDR+3, then NONSEQ read of BASE_ADDR+3 → HRDATA=32'hDEAD_BEEF in the read data phase, HREADYOUT=1, HRESP=0.
- **Decrementing INCR burst.**
  - Preload offsets 10..7 with 32'h10..32'h07.
  - Bus issues NONSEQ 10, then SEQ 9, 8, 7, with one BUSY inserted after 9.
  - Expect HRDATA sequence 10, 9, 8, 7 with no wait states; the BUSY cycle returns OKAY with HRDATA=0.
- **Error.**
  - Read at BASE_ADDR+DEPTH → HREADYOUT 0 then 1, HRESP=1 for both cycles.
  - Write with HSIZE=3'b000 to offset 2 → same 2-cycle ERROR; offset 2 unchanged.
- **Pipelined write→read, same offset.** Write 32'h1234_5678 to offset 0 with the read of offset 0 in the following address phase → read returns 32'h1234_5678.
- **Macro build.** With AHB_SRAM_WAIT_STATE_EN defined, a read of offset 1 (holding 32'hA5A5_A5A5) → one cycle HREADYOUT=0, then HRDATA=32'hA5A5_A5A5 with HREADYOUT=1. A write stays zero-wait.
